// File: rtl/sc_dntransition_counter_pkg.sv
// Shared types for the down-transition counter: FSM state encoding and defaults.
package sc_dntransition_counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned STATE_W       = 2;

  localparam logic [STATE_W-1:0] ENC_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ENC_RUN   = 2'd1;
  localparam logic [STATE_W-1:0] ENC_PAUSE = 2'd2;
  localparam logic [STATE_W-1:0] ENC_DONE  = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = ENC_IDLE,
    ST_RUN   = ENC_RUN,
    ST_PAUSE = ENC_PAUSE,
    ST_DONE  = ENC_DONE
  } state_e;

  // A run is in progress (counting or frozen)
  function automatic logic is_busy(input state_e s);
    return (s == ST_RUN) || (s == ST_PAUSE);
  endfunction

endpackage

// File: rtl/sc_dntransition_counter_if.sv
// Control/status bundle of the down-transition counter.
interface sc_dntransition_counter_if
  import sc_dntransition_counter_pkg::*;
#(
  parameter int unsigned W = DEFAULT_WIDTH
);

  logic         load_InLow;
  logic [W-1:0] preset_InBUS;
  logic         dncount_InLow;
  logic         pause_InLow;
  logic [W-1:0] data_OutBUS;
  logic         zero_Out;
  logic         busy_Out;
  logic         done_OutPulse;

  modport master (
    output load_InLow, preset_InBUS, dncount_InLow, pause_InLow,
    input  data_OutBUS, zero_Out, busy_Out, done_OutPulse
  );

  modport slave (
    input  load_InLow, preset_InBUS, dncount_InLow, pause_InLow,
    output data_OutBUS, zero_Out, busy_Out, done_OutPulse
  );

endinterface

// File: rtl/sc_falledge_detect.sv
// 1-bit falling-edge detector; history clears to 0 so reset release never fakes an edge.
module sc_falledge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic fall_c_o
);

  logic hist_q;

  // Previous-cycle sample of the input
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) hist_q <= 1'b0;
    else       hist_q <= sig_i;
  end

  assign fall_c_o = hist_q & ~sig_i;

endmodule

// File: rtl/sc_dntransition_counter.sv
// Down counter decremented by falling transitions of dncount_InLow.
// Optional feature macro: SC_DNTRANSITIONCOUNTER_AUTORELOAD_EN (reload last preset at 1->0).
module sc_dntransition_counter
  import sc_dntransition_counter_pkg::*;
#(
  parameter int unsigned DNTRANSITIONCOUNTER_DATAWIDTH = DEFAULT_WIDTH
) (
  input  logic                      SC_upTRANSITION0COUNTER0_CLOCK_50,
  input  logic                      SC_upTRANSITION0COUNTER0R_RESET_InHigh,
  sc_dntransition_counter_if.slave  bus
);

  localparam int unsigned W = DNTRANSITIONCOUNTER_DATAWIDTH;

  logic         fall_c;
  state_e       state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic         zero_q, zero_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
`ifdef SC_DNTRANSITIONCOUNTER_AUTORELOAD_EN
  logic [W-1:0] shadow_q, shadow_d;
`endif

  sc_falledge_detect u_fall (
    .clk_i    (SC_upTRANSITION0COUNTER0_CLOCK_50),
    .rst_i    (SC_upTRANSITION0COUNTER0R_RESET_InHigh),
    .sig_i    (bus.dncount_InLow),
    .fall_c_o (fall_c)
  );

  // State, count and registered status flags
  always_ff @(posedge SC_upTRANSITION0COUNTER0_CLOCK_50 or posedge SC_upTRANSITION0COUNTER0R_RESET_InHigh) begin
    if (SC_upTRANSITION0COUNTER0R_RESET_InHigh) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      zero_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SC_DNTRANSITIONCOUNTER_AUTORELOAD_EN
      shadow_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SC_DNTRANSITIONCOUNTER_AUTORELOAD_EN
      shadow_q <= shadow_d;
`endif
    end
  end

  // Next state: load has priority; transitions only count while running
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    done_d   = 1'b0;
`ifdef SC_DNTRANSITIONCOUNTER_AUTORELOAD_EN
    shadow_d = shadow_q;
`endif
    if (!bus.load_InLow) begin
      count_d = bus.preset_InBUS;
`ifdef SC_DNTRANSITIONCOUNTER_AUTORELOAD_EN
      shadow_d = bus.preset_InBUS;
`endif
      if (bus.preset_InBUS == '0) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (!bus.pause_InLow) begin
            state_d = ST_PAUSE;
          end else if (fall_c) begin
            if (count_q <= W'(1)) begin
              done_d = 1'b1;
`ifdef SC_DNTRANSITIONCOUNTER_AUTORELOAD_EN
              count_d = shadow_q;
`else
              count_d = '0;
              state_d = ST_DONE;
`endif
            end else begin
              count_d = count_q - W'(1);
            end
          end
        end
        ST_PAUSE: begin
          if (bus.pause_InLow) state_d = ST_RUN;
        end
        default: begin
          // IDLE and DONE hold until the next load
        end
      endcase
    end
    zero_d = (count_d == '0);
    busy_d = is_busy(state_d);
  end

  assign bus.data_OutBUS   = count_q;
  assign bus.zero_Out      = zero_q;
  assign bus.busy_Out      = busy_q;
  assign bus.done_OutPulse = done_q;

endmodule

// File: tb/tb_sc_dntransition_counter.sv
// Bench for sc_dntransition_counter: directed scenarios then random traffic against a run-level model.
module tb_sc_dntransition_counter;

  localparam int unsigned W = 8;

  logic clk;
  logic rst;

  sc_dntransition_counter_if #(.W(W)) bus ();

  sc_dntransition_counter #(.DNTRANSITIONCOUNTER_DATAWIDTH(W)) dut (
    .SC_upTRANSITION0COUNTER0_CLOCK_50      (clk),
    .SC_upTRANSITION0COUNTER0R_RESET_InHigh (rst),
    .bus                                    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a run is "active" from a nonzero load until it reaches zero
  int m_cnt;
  int m_last;
  bit m_active;
  bit m_paused;
  bit m_prev_dn;
  bit m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data"}, 32'(bus.data_OutBUS),   32'(m_cnt));
    chk({tag, ".zero"}, 32'(bus.zero_Out),      32'(m_cnt == 0));
    chk({tag, ".busy"}, 32'(bus.busy_Out),      32'(m_active));
    chk({tag, ".done"}, 32'(bus.done_OutPulse), 32'(m_done));
  endtask

  task automatic model_reset();
    m_cnt     = 0;
    m_last    = 0;
    m_active  = 1'b0;
    m_paused  = 1'b0;
    m_prev_dn = 1'b0;
    m_done    = 1'b0;
  endtask

  // Apply the rules to the inputs seen at the edge just passed
  task automatic model_step();
    bit fall;
    fall      = m_prev_dn && !bus.dncount_InLow;
    m_prev_dn = bus.dncount_InLow;
    m_done    = 1'b0;
    if (!bus.load_InLow) begin
      m_cnt  = int'(bus.preset_InBUS);
      m_last = m_cnt;
      if (m_cnt == 0) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end else begin
        m_active = 1'b1;
        m_paused = 1'b0;
      end
    end else if (m_active) begin
      if (m_paused) begin
        if (bus.pause_InLow) m_paused = 1'b0;
      end else if (!bus.pause_InLow) begin
        m_paused = 1'b1;
      end else if (fall) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1'b1;
`ifdef SC_DNTRANSITIONCOUNTER_AUTORELOAD_EN
          m_cnt = m_last;
`else
          m_active = 1'b0;
`endif
        end
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    model_step();
    check_all(tag);
  endtask

  task automatic fall_once(input string tag);
    bus.dncount_InLow = 1'b1;
    tick(tag);
    bus.dncount_InLow = 1'b0;
    tick(tag);
  endtask

  task automatic load_val(input int v, input string tag);
    bus.preset_InBUS = W'(v);
    bus.load_InLow   = 1'b0;
    tick(tag);
    bus.load_InLow   = 1'b1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".hold"});
    rst = 1'b0;
  endtask

  initial begin
    rst               = 1'b0;
    bus.load_InLow    = 1'b1;
    bus.preset_InBUS  = '0;
    bus.dncount_InLow = 1'b1;
    bus.pause_InLow   = 1'b1;
    model_reset();
    #1;
    do_reset("reset");
    tick("post_reset");

    // Load 5, count down to zero
    load_val(5, "load5");
    for (int i = 0; i < 5; i++) fall_once("count5");
    tick("count5_after");
    chk("count5_final", 32'(bus.data_OutBUS), 32'(m_cnt));

    // Pause freezes counting
    load_val(3, "load3");
    bus.pause_InLow = 1'b0;
    for (int i = 0; i < 4; i++) fall_once("paused");
    chk("paused_data", 32'(bus.data_OutBUS), 32'd3);
    chk("paused_busy", 32'(bus.busy_Out), 32'd1);
    bus.pause_InLow = 1'b1;
    tick("unpause");
    fall_once("unpaused");
    chk("unpaused_data", 32'(bus.data_OutBUS), 32'd2);

    // Load 0 finishes immediately
    load_val(0, "load0");
    chk("load0_done", 32'(bus.done_OutPulse), 32'd1);
    tick("load0_after");

    // Load beats a simultaneous transition
    bus.dncount_InLow = 1'b1;
    tick("pre_load10");
    bus.preset_InBUS  = W'(10);
    bus.load_InLow    = 1'b0;
    bus.dncount_InLow = 1'b0;
    tick("load10");
    bus.load_InLow    = 1'b1;
    chk("load_wins", 32'(bus.data_OutBUS), 32'd10);

    // Reset mid-run aborts without a done pulse
    load_val(200, "load200");
    for (int i = 0; i < 50; i++) fall_once("run200");
    do_reset("midrun_reset");
    for (int i = 0; i < 3; i++) fall_once("after_reset");

    // Load 2, four transitions (reloads when auto-reload is built in)
    load_val(2, "load2");
    for (int i = 0; i < 4; i++) fall_once("load2_run");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset("rand_reset");
      bus.load_InLow    = ($urandom_range(0, 19) != 0);
      bus.preset_InBUS  = W'($urandom_range(0, 6));
      bus.dncount_InLow = 1'($urandom_range(0, 1));
      bus.pause_InLow   = ($urandom_range(0, 7) != 0);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
